// File: rtl/maj_net_eval.sv
// rtl/maj_net_eval.sv - programmable majority-inverter network truth-table evaluator
// One gate per clock, each gate evaluated bit-parallel over all 2^N_IN input assignments.
module maj_net_eval #(
  parameter int N_IN    = 7,
  parameter int N_GATES = 6,
  localparam int SELW   = $clog2(N_IN + N_GATES + 1),
  localparam int OPW    = SELW + 1,
  localparam int AW     = (N_GATES > 1) ? $clog2(N_GATES) : 1,
  localparam int W      = 1 << N_IN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [3*OPW-1:0] cfg_data,
  input  logic             out_inv,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     tt_out,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    k_q, k_d;
  logic [3*OPW-1:0] cfg_q [N_GATES];
  logic [3*OPW-1:0] cfg_d [N_GATES];
  logic [W-1:0]     r_q [N_GATES];
  logic [W-1:0]     r_d [N_GATES];
  logic             inv_q, inv_d;
  logic             err_run_q, err_run_d;
  logic [W-1:0]     tt_q, tt_d;
  logic             err_q, err_d;

  logic [3*OPW-1:0] cur_cfg;
  logic [W-1:0]     opnd [3];
  logic [2:0]       opnd_ill;
  logic [W-1:0]     maj_v;

  // Column i of the truth table: bit m is bit i of the minterm index m.
  function automatic logic [W-1:0] proj_vec(input int i);
    logic [W-1:0] v;
    for (int m = 0; m < W; m++) v[m] = 1'((m >> i) & 1);
    return v;
  endfunction

  always_comb begin
    int sel_i;
    cur_cfg  = '0;
    opnd_ill = '0;
    sel_i    = 0;
    for (int j = 0; j < N_GATES; j++) begin
      if (int'(k_q) == j) cur_cfg = cfg_q[j];
    end
    for (int o = 0; o < 3; o++) begin
      opnd[o] = '0;
      sel_i   = int'(cur_cfg[o*OPW +: SELW]);
      if (sel_i > N_IN + N_GATES) opnd_ill[o] = 1'b1;
      for (int i = 0; i < N_IN; i++) begin
        if (sel_i == i + 1) opnd[o] = proj_vec(i);
      end
      // Only results of strictly earlier gates are legal; anything else reads as 0.
      for (int j = 0; j < N_GATES; j++) begin
        if (sel_i == N_IN + 1 + j) begin
          if (j < int'(k_q)) opnd[o] = r_q[j];
          else               opnd_ill[o] = 1'b1;
        end
      end
      if (cur_cfg[o*OPW + SELW]) opnd[o] = ~opnd[o];
    end
    maj_v = (opnd[0] & opnd[1]) | (opnd[0] & opnd[2]) | (opnd[1] & opnd[2]);
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cfg_d     = cfg_q;
    r_d       = r_q;
    inv_d     = inv_q;
    err_run_d = err_run_q;
    tt_d      = tt_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          for (int j = 0; j < N_GATES; j++) begin
            if (int'(cfg_addr) == j) cfg_d[j] = cfg_data;
          end
        end
        if (start) begin
          inv_d     = out_inv;
          err_run_d = 1'b0;
          k_d       = '0;
          state_d   = S_EVAL;
        end
      end
      S_EVAL: begin
        for (int j = 0; j < N_GATES; j++) begin
          if (int'(k_q) == j) r_d[j] = maj_v;
        end
        err_run_d = err_run_q | (|opnd_ill);
        if (int'(k_q) == N_GATES - 1) begin
          tt_d    = maj_v ^ {W{inv_q}};
          err_d   = err_run_q | (|opnd_ill);
          state_d = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      inv_q     <= 1'b0;
      err_run_q <= 1'b0;
      tt_q      <= '0;
      err_q     <= 1'b0;
      for (int j = 0; j < N_GATES; j++) begin
        cfg_q[j] <= '0;
        r_q[j]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      inv_q     <= inv_d;
      err_run_q <= err_run_d;
      tt_q      <= tt_d;
      err_q     <= err_d;
      for (int j = 0; j < N_GATES; j++) begin
        cfg_q[j] <= cfg_d[j];
        r_q[j]   <= r_d[j];
      end
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign tt_out = tt_q;
  assign err    = err_q;

endmodule
